// File: rtl/proc_pkg.sv
// Shared types and constants for the filter processor front end.
package proc_pkg;

    localparam int INST_W = 16;
    localparam int ADDR_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 16'hffff;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous fetch queue; flush empties it and overrides any push or pop
// requested in the same cycle.
module inst_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot a same-cycle push needs, so full only blocks a lone push.
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= din;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads memory combinationally and
// queues {pc, word} pairs for decode, with branch flush and end-of-program halt.
module inst_fetch_ctrl
    import proc_pkg::*;
#(
    parameter int unsigned MEM_DEPTH  = 101,
    parameter int          FIFO_DEPTH = 2,
    parameter bit          DROP_NOP   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    output logic [ADDR_W-1:0]  o_mem_dir,
    input  logic [INST_W-1:0]  i_mem_data,
    output logic [INST_W-1:0]  o_inst,
    output logic [ADDR_W-1:0]  o_inst_pc,
    output logic               o_inst_valid,
    input  logic               i_inst_ready,
    input  logic               i_branch_taken,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic               o_halted,
    output logic               o_done,
    output fetch_state_t       dbg_state
);

    localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(MEM_DEPTH);

    fetch_state_t              state;
    fetch_state_t              state_next;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         pc_next;
    logic [ADDR_W-1:0]         pc_inc;
    logic                      pop;
    logic                      push;
    logic                      advance;
    logic                      is_nop;
    logic                      full;
    logic                      empty;
    logic [INST_W+ADDR_W-1:0]  head;

    // Handshake: a word moves to decode on a cycle where o_inst_valid and
    // i_inst_ready are both high; the head is held steady otherwise.
    assign pop     = o_inst_valid && i_inst_ready;
    assign pc_inc  = pc + ADDR_W'(1);
    assign advance = (state == FETCH) && i_en && !i_branch_taken && (!full || pop);
    assign is_nop  = DROP_NOP && (i_mem_data == NOP_INST);
    assign push    = advance && !is_nop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        if (i_branch_taken) begin
            pc_next = i_branch_target;
            if (i_branch_target >= END_PC) state_next = HALT;
            else if (i_en)                 state_next = FETCH;
            else                           state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_en) state_next = FETCH;
                end
                FETCH: begin
                    if (!i_en) begin
                        state_next = IDLE;
                    end else if (advance) begin
                        pc_next = pc_inc;
                        // The last word is still fetched; the PC parks one past it.
                        if (pc_inc >= END_PC) state_next = HALT;
                    end
                end
                HALT:    state_next = HALT;
                default: state_next = FETCH;
            endcase
        end
    end

    inst_fifo #(
        .WIDTH (INST_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (i_branch_taken),
        .din   ({pc, i_mem_data}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign o_mem_dir    = pc;
    assign o_inst       = head[INST_W-1:0];
    assign o_inst_pc    = head[INST_W +: ADDR_W];
    assign o_inst_valid = !empty;
    assign o_halted     = (state == HALT);
    assign o_done       = o_halted && empty;
    assign dbg_state    = state;

endmodule
